// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing plus test-pattern generator; every output is registered from the next pixel position,
// so timing, strobes and colour in any cycle all describe the hcount/vcount shown in that same cycle.
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int GRID_LOG2 = 4,
    parameter int CW        = 12
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic [1:0]    mode,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hs,
    output logic          vs,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BW_LAST = CW'(H_ACTIVE / 8 - 1);

    logic          r_run;
    logic [1:0]    r_mode;
    logic [CW-1:0] r_bcnt;
    logic [2:0]    r_bidx;
    logic          w_wrap_h;
    logic [CW-1:0] w_nh;
    logic [CW-1:0] w_nv;
    logic          w_nfs;
    logic [7:0]    w_nfc;
    logic [1:0]    w_nmode;
    logic [CW-1:0] w_nbc;
    logic [2:0]    w_nbi;
    logic          w_nhb;
    logic          w_nvb;
    logic          w_nde;
    logic          w_grid_on;
    logic [23:0]   w_bar;
    logic [23:0]   w_grid;
    logic [23:0]   w_rgb;

    // r_run is clear on the first edge after reset so that edge presents (0,0) instead of stepping past it
    always_comb begin
        w_wrap_h  = hcount == H_LAST;
        w_nh      = (!r_run || w_wrap_h) ? '0 : hcount + 1'b1;
        w_nv      = !r_run ? '0 : w_wrap_h ? ((vcount == V_LAST) ? '0 : vcount + 1'b1) : vcount;
        w_nfs     = (w_nh == '0) && (w_nv == '0);
        w_nfc     = (w_nfs && r_run) ? frame_count + 8'd1 : frame_count;
        w_nmode   = w_nfs ? mode : r_mode;
        w_nbc     = (w_nh == '0 || r_bcnt == BW_LAST) ? '0 : r_bcnt + 1'b1;
        w_nbi     = (w_nh == '0) ? 3'd0 : (r_bcnt == BW_LAST) ? r_bidx + 3'd1 : r_bidx;
        w_nhb     = w_nh >= H_ACT;
        w_nvb     = w_nv >= V_ACT;
        w_nde     = !w_nhb && !w_nvb;
        w_bar     = {{8{~w_nbi[1]}}, {8{~w_nbi[2]}}, {8{~w_nbi[0]}}};
        w_grid_on = (w_nh[GRID_LOG2-1:0] == '0) || (w_nv[GRID_LOG2-1:0] == '0) ||
                    (w_nh == H_ACT - 1'b1) || (w_nv == V_ACT - 1'b1);
        w_grid    = w_grid_on ? 24'hFFFFFF : {w_nfc, 8'h00, 8'h40};
        w_rgb     = !w_nde ? 24'h0 : (w_nmode == 2'd0) ? 24'h0 : (w_nmode == 2'd1) ? 24'hFFFFFF :
                    (w_nmode == 2'd2) ? w_bar : w_grid;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_run       <= 1'b0;
            r_mode      <= 2'd0;
            r_bcnt      <= '0;
            r_bidx      <= 3'd0;
            hcount      <= '0;
            vcount      <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            de          <= 1'b0;
            {r, g, b}   <= 24'h0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            r_run       <= 1'b1;
            r_mode      <= w_nmode;
            r_bcnt      <= w_nbc;
            r_bidx      <= w_nbi;
            hcount      <= w_nh;
            vcount      <= w_nv;
            hs          <= (w_nh >= HS_BEG && w_nh < HS_END) ? HS_POL : ~HS_POL;
            vs          <= (w_nv >= VS_BEG && w_nv < VS_END) ? VS_POL : ~VS_POL;
            hblank      <= w_nhb;
            vblank      <= w_nvb;
            de          <= w_nde;
            {r, g, b}   <= w_rgb;
            line_start  <= w_nh == '0;
            frame_start <= w_nfs;
            frame_count <= w_nfc;
        end
    end
endmodule
